// File: rtl/lcd_phrase_sequencer_pkg.sv
// Shared definitions for the LCD phrase sequencer: state encodings, HD44780
// command bytes, default wait cycle counts (50 MHz) and the init step table.
package lcd_phrase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT  = 3'd0,
    ST_INIT_REQ  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_IDLE      = 3'd3,
    ST_ADDR_REQ  = 3'd4,
    ST_CHAR_REQ  = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PW_NONE  = 2'd0,
    PW_4MS   = 2'd1,
    PW_100US = 2'd2,
    PW_CLEAR = 2'd3
  } post_wait_t;

  typedef struct packed {
    logic [7:0] data;
    logic       nibbleOnly;
    post_wait_t postWait;
  } init_step_t;

  localparam logic [7:0] CMD_FUNCSET = 8'h28;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;
  localparam logic [7:0] LINE2_OFS   = 8'h40;
  localparam logic [7:0] NIB_WAKE    = 8'h30;
  localparam logic [7:0] NIB_4BIT    = 8'h20;

  localparam int DEF_PWRON_CYC      = 750000;
  localparam int DEF_WAIT_4MS_CYC   = 205000;
  localparam int DEF_WAIT_100US_CYC = 5000;
  localparam int DEF_CLEAR_CYC      = 82000;

  localparam logic [2:0] LAST_INIT_STEP = 3'd7;
  localparam logic [3:0] LAST_CHAR_IDX  = 4'd15;

  // Power-on init table: three wake-up nibbles, switch to 4-bit, then the
  // full-byte configuration commands ending with a clear.
  function automatic init_step_t getInitStep(input logic [2:0] idx);
    init_step_t s;
    case (idx)
      3'd0:    s = '{data: NIB_WAKE,    nibbleOnly: 1'b1, postWait: PW_4MS};
      3'd1:    s = '{data: NIB_WAKE,    nibbleOnly: 1'b1, postWait: PW_100US};
      3'd2:    s = '{data: NIB_WAKE,    nibbleOnly: 1'b1, postWait: PW_100US};
      3'd3:    s = '{data: NIB_4BIT,    nibbleOnly: 1'b1, postWait: PW_100US};
      3'd4:    s = '{data: CMD_FUNCSET, nibbleOnly: 1'b0, postWait: PW_NONE};
      3'd5:    s = '{data: CMD_ENTRY,   nibbleOnly: 1'b0, postWait: PW_NONE};
      3'd6:    s = '{data: CMD_DISPON,  nibbleOnly: 1'b0, postWait: PW_NONE};
      default: s = '{data: CMD_CLEAR,   nibbleOnly: 1'b0, postWait: PW_CLEAR};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counting delay timer. A load of N expires N cycles later; a load of 0
// expires on the very next cycle. Shared with the nibble writer stage.
module lcd_delay_counter #(
  parameter logic [19:0] RESET_VALUE = 20'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iLoad,
  input  logic [19:0] iValue,
  output logic        oExpired
);

  logic [19:0] count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= RESET_VALUE;
    end else if (iLoad) begin
      count <= iValue;
    end else if (count != 20'd0) begin
      count <= count - 20'd1;
    end
  end

  // Expiry is purely a function of the current count.
  always_comb begin
    oExpired = (count == 20'd0);
  end

endmodule

// File: rtl/lcd_phrase_sequencer.sv
// Upstream controller for the 4-bit HD44780 writer: power-on init, then
// 16-character phrases as one DDRAM address command plus 16 data bytes.
//
// Byte handshake: oByteValid rises with oByte/oRS/oNibbleOnly already stable
// and holds them until the cycle iByteDone=1 is sampled; valid then drops on
// that edge and stays low for at least one cycle before the next request.
// iByteDone while oByteValid=0 is ignored.
module lcd_phrase_sequencer
  import lcd_phrase_sequencer_pkg::*;
#(
  parameter int PWRON_CYC      = DEF_PWRON_CYC,
  parameter int WAIT_4MS_CYC   = DEF_WAIT_4MS_CYC,
  parameter int WAIT_100US_CYC = DEF_WAIT_100US_CYC,
  parameter int CLEAR_CYC      = DEF_CLEAR_CYC
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [127:0] iPhrase,
  input  logic         iLine,
  input  logic         iStart,
  input  logic         iByteDone,
  output logic [7:0]   oByte,
  output logic         oRS,
  output logic         oNibbleOnly,
  output logic         oByteValid,
  output logic         oBusy,
  output logic         oDone,
  output logic [2:0]   oState
);

  localparam logic [19:0] PWRON_V = 20'(PWRON_CYC);
  localparam logic [19:0] W4MS_V  = 20'(WAIT_4MS_CYC);
  localparam logic [19:0] W100_V  = 20'(WAIT_100US_CYC);
  localparam logic [19:0] CLEAR_V = 20'(CLEAR_CYC);

  state_t       state;
  state_t       nextState;
  logic [2:0]   step;
  logic [3:0]   charIdx;
  logic [127:0] phraseReg;
  logic         lineReg;
  logic         holdOff;
  logic         accept;
  logic         loadDelay;
  logic [19:0]  loadValue;
  logic         delayExpired;
  init_step_t   stepInfo;

  assign stepInfo = getInitStep(step);
  assign accept   = oByteValid & iByteDone;
  assign oState   = state;

  lcd_delay_counter #(
    .RESET_VALUE (PWRON_V)
  ) uDelay (
    .Clock    (Clock),
    .Reset    (Reset),
    .iLoad    (loadDelay),
    .iValue   (loadValue),
    .oExpired (delayExpired)
  );

  // State register; reset always restarts the init sequence.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_PWR_WAIT;
    end else begin
      state <= nextState;
    end
  end

  // Next-state selection from handshake completions and delay expiry.
  always_comb begin
    nextState = state;
    case (state)
      ST_PWR_WAIT: begin
        if (delayExpired) nextState = ST_INIT_REQ;
      end
      ST_INIT_REQ: begin
        if (accept) begin
          if (stepInfo.postWait != PW_NONE)      nextState = ST_INIT_WAIT;
          else if (step == LAST_INIT_STEP)       nextState = ST_IDLE;
          else                                   nextState = ST_INIT_REQ;
        end
      end
      ST_INIT_WAIT: begin
        if (delayExpired) nextState = (step == LAST_INIT_STEP) ? ST_IDLE : ST_INIT_REQ;
      end
      ST_IDLE: begin
        if (iStart) nextState = ST_ADDR_REQ;
      end
      ST_ADDR_REQ: begin
        if (accept) nextState = ST_CHAR_REQ;
      end
      ST_CHAR_REQ: begin
        if (accept && charIdx == LAST_CHAR_IDX) nextState = ST_FINISH;
      end
      ST_FINISH: nextState = ST_IDLE;
      default:   nextState = ST_PWR_WAIT;
    endcase
  end

  // Post-wait load happens on the accept edge so counting starts the cycle after done.
  always_comb begin
    loadDelay = 1'b0;
    loadValue = 20'd0;
    if (state == ST_INIT_REQ && accept && stepInfo.postWait != PW_NONE) begin
      loadDelay = 1'b1;
      case (stepInfo.postWait)
        PW_4MS:   loadValue = W4MS_V;
        PW_100US: loadValue = W100_V;
        PW_CLEAR: loadValue = CLEAR_V;
        default:  loadValue = 20'd0;
      endcase
    end
  end

  // Step/char indices, phrase latch and the one-cycle gap after each accepted byte.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step      <= 3'd0;
      charIdx   <= 4'd0;
      phraseReg <= '0;
      lineReg   <= 1'b0;
      holdOff   <= 1'b0;
    end else begin
      holdOff <= accept;
      case (state)
        ST_PWR_WAIT: step <= 3'd0;
        ST_INIT_REQ: begin
          if (accept && stepInfo.postWait == PW_NONE) step <= step + 3'd1;
        end
        ST_INIT_WAIT: begin
          if (delayExpired) step <= step + 3'd1;
        end
        ST_IDLE: begin
          if (iStart) begin
            phraseReg <= iPhrase;
            lineReg   <= iLine;
          end
        end
        ST_ADDR_REQ: begin
          if (accept) charIdx <= 4'd0;
        end
        ST_CHAR_REQ: begin
          // 15 -> 0 wrap coincides with the move to FINISH.
          if (accept) charIdx <= charIdx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Request outputs per state; valid is masked during the post-accept gap.
  always_comb begin
    oByte       = 8'h00;
    oRS         = 1'b0;
    oNibbleOnly = 1'b0;
    oByteValid  = 1'b0;
    oBusy       = 1'b1;
    oDone       = 1'b0;
    case (state)
      ST_INIT_REQ: begin
        oByte       = stepInfo.data;
        oNibbleOnly = stepInfo.nibbleOnly;
        oByteValid  = ~holdOff;
      end
      ST_IDLE: oBusy = 1'b0;
      ST_ADDR_REQ: begin
        oByte      = CMD_DDRAM | (lineReg ? LINE2_OFS : 8'h00);
        oByteValid = ~holdOff;
      end
      ST_CHAR_REQ: begin
        oByte      = phraseReg[{charIdx, 3'b000} +: 8];
        oRS        = 1'b1;
        oByteValid = ~holdOff;
      end
      ST_FINISH: oDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_phrase_sequencer.sv
// Directed bench for lcd_phrase_sequencer with a 3-cycle writer model.
module tb_lcd_phrase_sequencer;
  import lcd_phrase_sequencer_pkg::*;

  localparam int PWRON = 20;
  localparam int W4    = 10;
  localparam int W100  = 5;
  localparam int WCLR  = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [127:0] iPhrase = '0;
  logic         iLine = 1'b0;
  logic         iStart = 1'b0;
  logic         iByteDone = 1'b0;
  logic [7:0]   oByte;
  logic         oRS;
  logic         oNibbleOnly;
  logic         oByteValid;
  logic         oBusy;
  logic         oDone;
  logic [2:0]   oState;

  lcd_phrase_sequencer #(
    .PWRON_CYC      (PWRON),
    .WAIT_4MS_CYC   (W4),
    .WAIT_100US_CYC (W100),
    .CLEAR_CYC      (WCLR)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPhrase     (iPhrase),
    .iLine       (iLine),
    .iStart      (iStart),
    .iByteDone   (iByteDone),
    .oByte       (oByte),
    .oRS         (oRS),
    .oNibbleOnly (oNibbleOnly),
    .oByteValid  (oByteValid),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oState      (oState)
  );

  // ---------------- clock / cycle count ----------------
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];   // {nibbleOnly, rs, byte}
  int gap_q[$];           // valid-low cycles before each request
  int writerDelay   = 3;
  int writeCnt      = 0;
  int unexpectedCnt = 0;
  int holdErr       = 0;
  int doneCnt       = 0;
  int lastDoneEdge  = 0;
  logic spurReq     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkPhrase(input string s);
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = s[k];
    return p;
  endfunction

  // ---------------- writer model ----------------
  initial begin : writer
    int lowCnt;
    int wcnt;
    logic inReq;
    logic [9:0] held;
    logic [9:0] cur;
    logic [9:0] e;
    lowCnt = 0;
    wcnt = 0;
    inReq = 1'b0;
    held = '0;
    forever begin
      @(negedge Clock);
      cur = {oNibbleOnly, oRS, oByte};
      if (Reset) begin
        iByteDone = 1'b0;
        inReq = 1'b0;
        lowCnt = 0;
        wcnt = 0;
      end else begin
        if (iByteDone) begin
          iByteDone = 1'b0;
          inReq = 1'b0;
          lowCnt = 0;
        end
        if (oDone) doneCnt++;
        if (!oByteValid) begin
          lowCnt++;
          if (spurReq) begin
            iByteDone = 1'b1;
            spurReq = 1'b0;
          end
        end else if (!inReq) begin
          inReq = 1'b1;
          wcnt = 1;
          held = cur;
          gap_q.push_back(lowCnt);
          writeCnt++;
          if (exp_q.size() == 0) unexpectedCnt++;
          else begin
            e = exp_q.pop_front();
            chk("write", 32'(cur), 32'(e));
          end
        end else begin
          wcnt++;
          if (cur !== held) holdErr++;
        end
        if (oByteValid && inReq && wcnt == writerDelay) begin
          iByteDone = 1'b1;
          lastDoneEdge = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called with Reset high and already sampled; releases it and runs init.
  task automatic runInit(input string tag);
    int r0;
    int firstValid;
    int expGap[7];
    logic idleSeen;
    expGap = '{W4 + 1, W100 + 1, W100 + 1, W100 + 1, 1, 1, 1};
    exp_q.delete();
    gap_q.delete();
    exp_q.push_back({1'b1, 1'b0, 8'h30});
    exp_q.push_back({1'b1, 1'b0, 8'h30});
    exp_q.push_back({1'b1, 1'b0, 8'h30});
    exp_q.push_back({1'b1, 1'b0, 8'h20});
    exp_q.push_back({1'b0, 1'b0, 8'h28});
    exp_q.push_back({1'b0, 1'b0, 8'h06});
    exp_q.push_back({1'b0, 1'b0, 8'h0C});
    exp_q.push_back({1'b0, 1'b0, 8'h01});
    Reset = 1'b0;
    r0 = cyc;
    firstValid = -1;
    // counter holds PWRON after the last reset edge; valid appears PWRON+1 edges later
    for (int i = 0; i < 200 && firstValid < 0; i++) begin
      @(negedge Clock);
      if (oByteValid) firstValid = cyc - r0;
      if (i == 4) iStart = 1'b1;
      if (i == 5) iStart = 1'b0;
    end
    chk({tag, "_pwron_latency"}, 32'(firstValid), 32'(PWRON + 1));
    idleSeen = 1'b0;
    for (int i = 0; i < 2000 && !idleSeen; i++) begin
      @(negedge Clock);
      if (!oBusy) idleSeen = 1'b1;
      else begin
        iStart = (i == 30);
      end
    end
    iStart = 1'b0;
    chk({tag, "_idle_reached"}, 32'(idleSeen), 32'd1);
    // clear wait loaded on the done edge, expires CLEAR edges later, IDLE one edge after
    chk({tag, "_clear_wait"}, 32'(cyc - lastDoneEdge), 32'(WCLR + 1));
    chk({tag, "_init_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_gap_count"}, 32'(gap_q.size()), 32'd8);
    if (gap_q.size() == 8) begin
      void'(gap_q.pop_front());
      for (int k = 0; k < 7; k++) chk({tag, "_gap"}, 32'(gap_q.pop_front()), 32'(expGap[k]));
    end
  endtask

  task automatic printPhrase(input string tag, input logic [127:0] ph, input logic line,
                             input int changeAt, input logic [127:0] ph2, input int bound);
    int wc0;
    int dc0;
    logic doneSeen;
    logic pulsed;
    wc0 = writeCnt;
    dc0 = doneCnt;
    exp_q.push_back({1'b0, 1'b0, line ? 8'hC0 : 8'h80});
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, 1'b1, ph[8*k +: 8]});
    iPhrase = ph;
    iLine = line;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    chk({tag, "_start_latency"}, 32'(oByteValid), 32'd1);
    doneSeen = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < bound && !doneSeen; i++) begin
      @(negedge Clock);
      if (oDone) doneSeen = 1'b1;
      if (iStart) iStart = 1'b0;
      else if (!pulsed && (writeCnt - wc0) >= changeAt) begin
        iPhrase = ph2;
        iLine = ~line;
        iStart = 1'b1;
        pulsed = 1'b1;
      end
    end
    iStart = 1'b0;
    chk({tag, "_done_seen"}, 32'(doneSeen), 32'd1);
    @(negedge Clock);
    chk({tag, "_busy_low"}, 32'(oBusy), 32'd0);
    repeat (5) @(negedge Clock);
    chk({tag, "_writes"}, 32'(writeCnt - wc0), 32'd17);
    chk({tag, "_done_pulses"}, 32'(doneCnt - dc0), 32'd1);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int wc0;
    int dc0;
    logic reached;

    repeat (3) @(negedge Clock);
    chk("rst_byte", 32'(oByte), 32'h00);
    chk("rst_rs", 32'(oRS), 32'd0);
    chk("rst_nib", 32'(oNibbleOnly), 32'd0);
    chk("rst_valid", 32'(oByteValid), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd1);
    chk("rst_state", 32'(oState), 32'(ST_PWR_WAIT));

    runInit("init1");

    printPhrase("hello", mkPhrase("HELLO WORLD     "), 1'b1, 3, mkPhrase("HELLO WORLD     "), 500);
    printPhrase("alpha", mkPhrase("ABCDEFGHIJKLMNOP"), 1'b0, 5, mkPhrase("zzzzzzzzzzzzzzzz"), 500);

    writerDelay = 100;
    printPhrase("stall", mkPhrase("Stall test 0123!"), 1'b1, 2, mkPhrase("xxxxxxxxxxxxxxxx"), 4000);
    writerDelay = 3;
    chk("stall_hold", 32'(holdErr), 32'd0);

    // spurious done in IDLE
    wc0 = writeCnt;
    spurReq = 1'b1;
    repeat (4) @(negedge Clock);
    chk("spur_state", 32'(oState), 32'(ST_IDLE));
    chk("spur_valid", 32'(oByteValid), 32'd0);
    chk("spur_writes", 32'(writeCnt - wc0), 32'd0);

    // reset while char 7 is being requested
    wc0 = writeCnt;
    dc0 = doneCnt;
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, 1'b1, 8'h30 + 8'(k)});
    exp_q.push_front({1'b0, 1'b0, 8'h80});
    iPhrase = mkPhrase("0123456789:;<=>?");
    iLine = 1'b0;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if ((writeCnt - wc0) >= 8) reached = 1'b1;
      else @(negedge Clock);
    end
    chk("rst_mid_reached", 32'(reached), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_mid_valid", 32'(oByteValid), 32'd0);
    chk("rst_mid_busy", 32'(oBusy), 32'd1);
    chk("rst_mid_state", 32'(oState), 32'(ST_PWR_WAIT));
    runInit("init2");
    chk("rst_mid_no_done", 32'(doneCnt - dc0), 32'd0);

    printPhrase("after", mkPhrase("Back again      "), 1'b1, 4, mkPhrase("Back again      "), 500);
    chk("extra_writes", 32'(unexpectedCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
